// File: rtl/branch_resolver.sv
// branch_resolver: EX-stage branch/jump resolution with registered redirect and optional 2-bit BHT.
// Define BRANCH_PREDICT_EN to build the predictor table; otherwise branches are predicted not taken.
module branch_resolver #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR = 32'h8000_0000,
    parameter int BHT_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  stall,
    input  logic                  ex_valid,
    input  logic                  ex_branch,
    input  logic                  ex_jal,
    input  logic                  ex_jalr,
    input  logic [2:0]            ex_funct3,
    input  logic [ADDR_WIDTH-1:0] ex_pc,
    input  logic [DATA_WIDTH-1:0] ex_imm,
    input  logic [DATA_WIDTH-1:0] ex_rs1,
    input  logic [DATA_WIDTH-1:0] ex_rs2,
    input  logic                  ex_pred_taken,
    input  logic [ADDR_WIDTH-1:0] if_pc,
    output logic                  if_pred_taken,
    output logic                  flush,
    output logic                  use_branch,
    output logic [ADDR_WIDTH-1:0] branch_out,
    output logic [31:0]           branch_cnt,
    output logic [31:0]           mispredict_cnt
);
    localparam int IW = $clog2(BHT_DEPTH);

    logic                  accept, eq, lt, ltu, taken, mispredict, redirect, br_upd;
    logic [ADDR_WIDTH-1:0] imm_a, pc_imm, pc_4, jalr_t, target;
    logic [DATA_WIDTH-1:0] rs1_imm;

    assign accept  = ex_valid & !stall & !flush;
    assign eq      = ex_rs1 == ex_rs2;
    assign lt      = $signed(ex_rs1) < $signed(ex_rs2);
    assign ltu     = ex_rs1 < ex_rs2;
    assign taken   = ex_funct3[2] ? ((ex_funct3[1] ? ltu : lt) ^ ex_funct3[0])
                                  : (!ex_funct3[1] & (eq ^ ex_funct3[0]));
    assign imm_a   = ADDR_WIDTH'($signed(ex_imm));
    assign pc_imm  = ex_pc + imm_a;
    assign pc_4    = ex_pc + ADDR_WIDTH'(4);
    assign rs1_imm = ex_rs1 + ex_imm;
    assign jalr_t  = ADDR_WIDTH'(rs1_imm) & ~ADDR_WIDTH'(1);
    assign target  = ex_jalr ? jalr_t : (ex_jal | taken) ? pc_imm : pc_4;
    // jalr > jal > branch: a jump never touches the predictor or the counters
    assign br_upd  = accept & ex_branch & !ex_jal & !ex_jalr;
    assign redirect = accept & (ex_jal | ex_jalr | (ex_branch & mispredict));
    assign use_branch = flush;

`ifdef BRANCH_PREDICT_EN
    logic [1:0]    bht [BHT_DEPTH];
    logic [IW-1:0] ex_idx, if_idx;
    assign ex_idx        = ex_pc[IW+1:2];
    assign if_idx        = if_pc[IW+1:2];
    assign if_pred_taken = bht[if_idx][1];
    assign mispredict    = taken != ex_pred_taken;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
        end else if (br_upd) begin
            bht[ex_idx] <= taken ? (&bht[ex_idx] ? 2'b11 : bht[ex_idx] + 2'b01)
                                 : (|bht[ex_idx] ? bht[ex_idx] - 2'b01 : 2'b00);
        end
    end
`else
    assign if_pred_taken = 1'b0;
    assign mispredict    = taken;
`endif

    logic unused;
    assign unused = ^{if_pc, ex_pred_taken};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush          <= 1'b0;
            branch_out     <= PC_ADDR;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            flush <= redirect;
            if (redirect) branch_out <= target;
            if (br_upd && branch_cnt != '1) branch_cnt <= branch_cnt + 32'd1;
            if (br_upd && mispredict && mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed test-plan sequences plus random traffic against a spec-level model.
module tb_branch_resolver;
    logic        clk = 0, reset_n = 0, stall = 0, ex_valid = 0, ex_branch = 0, ex_jal = 0, ex_jalr = 0;
    logic [2:0]  ex_funct3 = 0;
    logic [31:0] ex_pc = 0, ex_imm = 0, ex_rs1 = 0, ex_rs2 = 0, if_pc = 0;
    logic        ex_pred_taken = 0;
    logic        if_pred_taken, flush, use_branch;
    logic [31:0] branch_out, branch_cnt, mispredict_cnt;
    int checks = 0, failures = 0;
    int m_bht [16];
    logic        m_flush;
    logic [31:0] m_out, m_bc, m_mc;

    branch_resolver dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .ex_valid(ex_valid), .ex_branch(ex_branch),
        .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pred_taken(ex_pred_taken), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .flush(flush), .use_branch(use_branch), .branch_out(branch_out),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 0;
        endcase
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
`ifdef BRANCH_PREDICT_EN
        return m_bht[pc[5:2]] >= 2;
`else
        return pc[0] & 1'b0;
`endif
    endfunction

    task automatic m_reset();
        m_flush = 0; m_out = 32'h8000_0000; m_bc = 0; m_mc = 0;
        foreach (m_bht[i]) m_bht[i] = 1;
    endtask

    task automatic m_step();
        bit acc, tk, mis, nf;
        acc = ex_valid && !stall && !m_flush;
        nf = 0;
        if (acc && (ex_jalr || ex_jal)) begin
            nf = 1;
            m_out = ex_jalr ? ((ex_rs1 + ex_imm) & ~32'd1) : ex_pc + ex_imm;
        end else if (acc && ex_branch) begin
            tk = cond(ex_funct3, ex_rs1, ex_rs2);
`ifdef BRANCH_PREDICT_EN
            mis = tk != ex_pred_taken;
            m_bht[ex_pc[5:2]] = tk ? ((m_bht[ex_pc[5:2]] < 3) ? m_bht[ex_pc[5:2]] + 1 : 3)
                                   : ((m_bht[ex_pc[5:2]] > 0) ? m_bht[ex_pc[5:2]] - 1 : 0);
`else
            mis = tk;
`endif
            if (m_bc != 32'hFFFF_FFFF) m_bc++;
            if (mis) begin
                nf = 1;
                m_out = tk ? ex_pc + ex_imm : ex_pc + 4;
                if (m_mc != 32'hFFFF_FFFF) m_mc++;
            end
        end
        m_flush = nf;
    endtask

    task automatic check_outs();
        chk("flush", {31'd0, flush}, {31'd0, m_flush});
        chk("use_branch", {31'd0, use_branch}, {31'd0, m_flush});
        chk("branch_out", branch_out, m_out);
        chk("branch_cnt", branch_cnt, m_bc);
        chk("mispredict_cnt", mispredict_cnt, m_mc);
    endtask

    // inputs are already driven; compare prediction, advance model, clock, compare registered outputs
    task automatic cycle();
        #1;
        chk("if_pred_taken", {31'd0, if_pred_taken}, {31'd0, m_pred(if_pc)});
        m_step();
        @(posedge clk); #1;
        check_outs();
    endtask

    task automatic do_reset();
        reset_n = 0;
        m_reset();
        #1;
        check_outs();
        chk("reset_pred", {31'd0, if_pred_taken}, 32'd0);
        @(posedge clk); #1;
        check_outs();
        reset_n = 1;
        #1;
    endtask

    task automatic drive(input bit v, input bit b, input bit j, input bit jr, input logic [2:0] f,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] a,
                         input logic [31:0] c, input bit p);
        ex_valid = v; ex_branch = b; ex_jal = j; ex_jalr = jr; ex_funct3 = f;
        ex_pc = pc; ex_imm = imm; ex_rs1 = a; ex_rs2 = c; ex_pred_taken = p;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'd5;
            4: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        m_reset();
        @(posedge clk); #1;
        do_reset();
        drive(1, 1, 0, 0, 3'd0, 32'h8000_0010, -32'sd16, 32'd5, 32'd5, 0); cycle();
        chk("beq_flush", {31'd0, flush}, 32'd1);
        chk("beq_out", branch_out, 32'h8000_0000);
        chk("beq_mc", mispredict_cnt, 32'd1);
        drive(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0); cycle();
        chk("beq_flush_drop", {31'd0, flush}, 32'd0);
        drive(1, 1, 0, 0, 3'd4, 32'h8000_0020, 32'd8, 32'hFFFF_FFFF, 32'd1, 0); cycle();
        chk("blt_out", branch_out, 32'h8000_0028);
        drive(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0); cycle();
        drive(1, 1, 0, 0, 3'd6, 32'h8000_0020, 32'd8, 32'hFFFF_FFFF, 32'd1, 0); cycle();
        chk("bltu_flush", {31'd0, flush}, 32'd0);
        chk("bltu_bc", branch_cnt, 32'd3);
        drive(1, 0, 0, 1, 3'd0, 32'h8000_0040, 32'd4, 32'h8000_0101, 32'd0, 0); cycle();
        chk("jalr_out", branch_out, 32'h8000_0104);
        chk("jalr_bc", branch_cnt, 32'd3);
        drive(1, 1, 0, 0, 3'd0, 32'h8000_0010, -32'sd16, 32'd5, 32'd5, 0); cycle();
        chk("in_flush_ignored", {31'd0, flush}, 32'd0);
        stall = 1; cycle();
        chk("stall_flush", {31'd0, flush}, 32'd0);
        chk("stall_bc", branch_cnt, 32'd3);
        stall = 0; cycle();
        chk("unstall_flush", {31'd0, flush}, 32'd1);
        chk("unstall_mc", mispredict_cnt, 32'd3);
        drive(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0); cycle();
        drive(1, 1, 0, 0, 3'd0, 32'h8000_0010, -32'sd16, 32'd5, 32'd5, 0);
        do_reset();
        chk("reset_abandon", {31'd0, flush}, 32'd0);
        for (int n = 0; n < 3000; n++) begin
            ex_valid = $urandom_range(0, 9) < 8;
            ex_branch = $urandom_range(0, 3) != 0;
            ex_jal = $urandom_range(0, 7) == 0;
            ex_jalr = $urandom_range(0, 7) == 0;
            ex_funct3 = 3'($urandom);
            ex_pc = 32'h8000_0000 + 32'($urandom_range(0, 31)) * 4;
            ex_imm = $urandom_range(0, 1) ? 32'($signed($urandom_range(0, 255)) - 128) : $urandom;
            ex_rs1 = rnd_op();
            ex_rs2 = rnd_op();
            ex_pred_taken = $urandom_range(0, 1) ? m_pred(ex_pc) : 1'($urandom);
            if_pc = $urandom_range(0, 1) ? ex_pc : 32'h8000_0000 + 32'($urandom_range(0, 31)) * 4;
            stall = $urandom_range(0, 99) < 15;
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
